input_interface: RTL
====================

INPUT_INTERFACE -- requirements
Module: input_interface

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-003 SHALL have port: pushin  input  1  beat valid on this cycle.
REQ-004 SHALL have port: dinix  input  3  beat index 0..7 within a 1600-bit block.
REQ-005 SHALL have port: din  input  200  beat payload; beat k maps to block bits [200k+199:200k].
REQ-006 SHALL have port: tagin  input  8  block tag; meaningful only on the beat with dinix=0.
REQ-007 SHALL have port: dout  output  1600  assembled block.
REQ-008 SHALL have port: tagout  output  8  tag of block on dout.
REQ-009 SHALL have port: pushout  output  1  one-cycle pulse; dout/tagout valid.
REQ-010 SHALL have port: err  output  1  one-cycle pulse; protocol violation detected.
REQ-011 SHALL have parameter: NBEATS, default 8, beats per block.
REQ-012 SHALL have parameter: BEATW, default 200, beat width in bits.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (expects dinix=0) and FILL (expects dinix=expix).
REQ-014 SHALL hold a 3-bit expected-index counter expix; it is 0 in IDLE.
REQ-015 IDLE + pushin + dinix=0: SHALL write din into slice 0, capture tagin, set expix=1, go to FILL.
REQ-016 IDLE + pushin + dinix!=0: SHALL drop the beat, pulse err the next cycle, and stay in IDLE.
REQ-017 FILL + pushin + dinix=expix<7: SHALL write slice expix, increment expix, and stay in FILL.
REQ-018 FILL + pushin + dinix=7=expix: SHALL write slice 7, copy the full block and tag to the output registers, pulse pushout the next cycle, set expix=0, and go to IDLE.
REQ-019 FILL + pushin + dinix=0: SHALL abort the partial block, pulse err, treat the beat as a new block start (as REQ-015), and stay in FILL with expix=1.
REQ-020 FILL + pushin + other mismatched dinix: SHALL abort the partial block, pulse err, drop the beat, and go to IDLE.
REQ-021 No pushin: SHALL leave the state, expix and registers unchanged; beat gaps of any length are legal.
REQ-022 Latency: pushout SHALL assert exactly 1 cycle after the cycle in which the final beat is accepted.
REQ-023 dout/tagout SHALL hold their values until the next completed block; the following block's assembly SHALL NOT disturb them.
REQ-024 Back-to-back blocks: beat 0 of block N+1 in the cycle after beat 7 of block N SHALL be accepted without loss.
REQ-025 err and pushout SHALL never assert in the same cycle for the same beat; err SHALL be a single-cycle pulse per violation.
REQ-026 expix arithmetic SHALL be modulo NBEATS; there SHALL be no overflow path beyond 7.

Reset
REQ-027 reset=0 at a clk edge SHALL force IDLE, expix=0, pushout=0, err=0, dout=0, tagout=0, and clear the assembly buffer.
REQ-028 reset mid-block SHALL discard the partial block silently, without an err pulse.
REQ-029 A pushin in the same cycle as reset=0 SHALL be ignored.

Structure
REQ-030 The shared package SHALL hold NBEATS, BEATW, block width (1600), tag width (8) and the FSM state enum.
REQ-031 The slice-write decoder (dinix -> 200-bit write enables) SHALL be one sub-module named beat_slice_writer; all other logic SHALL stay in input_interface.

Verification
REQ-032 Beats 0..7 with din=k replicated per beat and tagin=0x5A on beat 0 -> pushout 1 cycle after beat 7; dout slice k = k; tagout=0x5A.
REQ-033 Beats 0,1,2 then beat 5 -> err pulse 1 cycle later, no pushout, FSM in IDLE; a subsequent clean block completes normally.
REQ-034 Beats 0..3 then beat 0 with tagin=0x11, then beats 1..7 -> one err pulse, one pushout, tagout=0x11.
REQ-035 Two blocks back-to-back with no idle cycles, tags 0xA1 and 0xB2 -> two pushout pulses 8 cycles apart; first dout held until second pushout.
REQ-036 reset=0 after beat 4, then a full block -> no err; only one pushout; dout/tagout zero until then.
REQ-037 pushin with dinix=3 while IDLE -> err pulse; dout/tagout unchanged.

Source files
------------

// File: rtl/input_interface_pkg.sv
// Shared widths and FSM state encoding for the beat-to-block assembler.
package input_interface_pkg;

    localparam int unsigned NBEATS = 8;
    localparam int unsigned BEATW  = 200;
    localparam int unsigned BLKW   = NBEATS * BEATW;
    localparam int unsigned TAGW   = 8;
    localparam int unsigned IDXW   = $clog2(NBEATS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

endpackage

// File: rtl/input_interface_beat_slice_writer.sv
// Decodes a beat index into per-slice write enables and merges the beat
// into the assembly buffer image.
module beat_slice_writer
    import input_interface_pkg::*;
#(
    parameter int unsigned NBEATS = input_interface_pkg::NBEATS,
    parameter int unsigned BEATW  = input_interface_pkg::BEATW
) (
    input  logic                       we_i,
    input  logic [$clog2(NBEATS)-1:0]  idx_i,
    input  logic [BEATW-1:0]           beat_i,
    input  logic [NBEATS*BEATW-1:0]    blk_i,
    output logic [NBEATS*BEATW-1:0]    blk_o_c
);

    localparam int unsigned IDX_W = $clog2(NBEATS);

    logic [NBEATS-1:0] slice_we_c;

    // One-hot slice enable from the beat index.
    always_comb begin
        slice_we_c = '0;
        for (int unsigned k = 0; k < NBEATS; k++) begin
            slice_we_c[k] = we_i && (idx_i == IDX_W'(k));
        end
    end

    // Replace the enabled slice, pass the rest through.
    always_comb begin
        blk_o_c = blk_i;
        for (int unsigned k = 0; k < NBEATS; k++) begin
            if (slice_we_c[k]) begin
                blk_o_c[k*BEATW +: BEATW] = beat_i;
            end
        end
    end

endmodule

// File: rtl/input_interface.sv
// Assembles NBEATS indexed beats into one block, publishes completed blocks
// with a one-cycle pushout and flags out-of-order beats with a one-cycle err.
module input_interface
    import input_interface_pkg::*;
#(
    parameter int unsigned NBEATS = input_interface_pkg::NBEATS,
    parameter int unsigned BEATW  = input_interface_pkg::BEATW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pushin,
    input  logic [$clog2(NBEATS)-1:0]  dinix,
    input  logic [BEATW-1:0]           din,
    input  logic [TAGW-1:0]            tagin,
    output logic [NBEATS*BEATW-1:0]    dout,
    output logic [TAGW-1:0]            tagout,
    output logic                       pushout,
    output logic                       err
);

    localparam int unsigned IDX_W = $clog2(NBEATS);
    localparam int unsigned BLK_W = NBEATS * BEATW;
    localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(NBEATS - 1);

    state_e             state_q,  state_d;
    logic [IDX_W-1:0]   expix_q,  expix_d;
    logic [BLK_W-1:0]   asm_q,    asm_c;
    logic [TAGW-1:0]    tag_q,    tag_d;
    logic [BLK_W-1:0]   dout_q,   dout_d;
    logic [TAGW-1:0]    tagout_q, tagout_d;
    logic               pushout_q, pushout_d;
    logic               err_q,    err_d;
    logic               beat_we_c;

    beat_slice_writer #(
        .NBEATS (NBEATS),
        .BEATW  (BEATW)
    ) u_writer (
        .we_i    (beat_we_c),
        .idx_i   (dinix),
        .beat_i  (din),
        .blk_i   (asm_q),
        .blk_o_c (asm_c)
    );

    // Next-state, slice write and output-register updates per accepted beat.
    always_comb begin
        state_d   = state_q;
        expix_d   = expix_q;
        tag_d     = tag_q;
        dout_d    = dout_q;
        tagout_d  = tagout_q;
        pushout_d = 1'b0;
        err_d     = 1'b0;
        beat_we_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pushin) begin
                    if (dinix == '0) begin
                        beat_we_c = 1'b1;
                        tag_d     = tagin;
                        expix_d   = IDX_W'(1);
                        state_d   = ST_FILL;
                    end else begin
                        err_d     = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (pushin) begin
                    if (dinix == expix_q) begin
                        beat_we_c = 1'b1;
                        if (expix_q == LAST_IX) begin
                            dout_d    = asm_c;
                            tagout_d  = tag_q;
                            pushout_d = 1'b1;
                            expix_d   = '0;
                            state_d   = ST_IDLE;
                        end else begin
                            expix_d   = expix_q + IDX_W'(1);
                        end
                    end else if (dinix == '0) begin
                        // Restart: the stray beat 0 opens a fresh block.
                        err_d     = 1'b1;
                        beat_we_c = 1'b1;
                        tag_d     = tagin;
                        expix_d   = IDX_W'(1);
                    end else begin
                        err_d     = 1'b1;
                        expix_d   = '0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                expix_d = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            expix_q   <= '0;
            asm_q     <= '0;
            tag_q     <= '0;
            dout_q    <= '0;
            tagout_q  <= '0;
            pushout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            expix_q   <= expix_d;
            asm_q     <= asm_c;
            tag_q     <= tag_d;
            dout_q    <= dout_d;
            tagout_q  <= tagout_d;
            pushout_q <= pushout_d;
            err_q     <= err_d;
        end
    end

    assign dout    = dout_q;
    assign tagout  = tagout_q;
    assign pushout = pushout_q;
    assign err     = err_q;

endmodule
